// File: rtl/tx_mod_framer.sv
// TX framer/modulator: prepends a fixed BPSK header to each byte-fed frame, then
// maps payload bits to BPSK or QPSK I/Q samples, each held for SPS output beats.
module tx_mod_framer #(
  parameter int unsigned          IQ_W    = 12,
  parameter int unsigned          AMP     = 1448,
  parameter int unsigned          SPS     = 1,
  parameter int unsigned          HDR_LEN = 16,
  parameter logic [HDR_LEN-1:0]   HDR_SEQ = 16'hEB90
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  input  logic                in_last,
  output logic                in_ready,
  output logic                out_valid,
  output logic [2*IQ_W-1:0]   out_data,
  output logic                out_last,
  input  logic                out_ready
);

  localparam int unsigned SYM_W = (HDR_LEN > 8) ? $clog2(HDR_LEN) : 3;
  localparam int unsigned REP_W = (SPS > 1) ? $clog2(SPS) : 1;

  localparam logic [IQ_W-1:0] POS_AMP = IQ_W'(AMP);
  localparam logic [IQ_W-1:0] NEG_AMP = IQ_W'(-$signed({1'b0, POS_AMP}));

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY
  } state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [SYM_W-1:0]   sym_q, sym_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               full_q, full_d;
  logic               last_q, last_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [2*IQ_W-1:0]  out_data_q, out_data_d;

  logic               fire;
  logic               rep_last;
  logic               pay_done;
  logic [SYM_W-1:0]   sym_max;
  logic [SYM_W-1:0]   sym_max_d;
  logic [SYM_W-1:0]   hdr_idx;

  function automatic logic [IQ_W-1:0] map_bit(input logic b);
    return b ? NEG_AMP : POS_AMP;
  endfunction

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    sym_d       = sym_q;
    rep_d       = rep_q;
    shreg_d     = shreg_q;
    full_d      = full_q;
    last_d      = last_q;
    in_ready    = 1'b0;
    pay_done    = 1'b0;
    fire        = out_valid_q && out_ready;
    rep_last    = (rep_q == REP_W'(SPS - 1));
    sym_max     = mode_q ? SYM_W'(3) : SYM_W'(7);

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = HDR;
          mode_d  = mode;
          sym_d   = '0;
          rep_d   = '0;
          full_d  = 1'b0;
          last_d  = 1'b0;
        end
      end
      HDR: begin
        if (fire) begin
          if (rep_last) begin
            rep_d = '0;
            if (sym_q == SYM_W'(HDR_LEN - 1)) begin
              state_d = PAY;
              sym_d   = '0;
            end else begin
              sym_d = sym_q + SYM_W'(1);
            end
          end else begin
            rep_d = rep_q + REP_W'(1);
          end
        end
      end
      PAY: begin
        pay_done = fire && rep_last && (sym_q == sym_max);
        in_ready = !full_q || (pay_done && !last_q);
        if (fire) begin
          if (rep_last) begin
            rep_d   = '0;
            sym_d   = (sym_q == sym_max) ? '0 : sym_q + SYM_W'(1);
            shreg_d = mode_q ? {shreg_q[5:0], 2'b00} : {shreg_q[6:0], 1'b0};
          end else begin
            rep_d = rep_q + REP_W'(1);
          end
        end
        if (pay_done) begin
          full_d = 1'b0;
          if (last_q) begin
            state_d = IDLE;
            last_d  = 1'b0;
          end
        end
        // A byte taken in the same cycle as the previous byte's final beat overrides the drain above.
        if (in_valid && in_ready) begin
          shreg_d = in_data;
          last_d  = in_last;
          full_d  = 1'b1;
          sym_d   = '0;
          rep_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered: the next sample is derived from the next-state values.
  always_comb begin
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    out_data_d  = '0;
    sym_max_d   = mode_d ? SYM_W'(3) : SYM_W'(7);
    hdr_idx     = SYM_W'(HDR_LEN - 1) - sym_d;
    unique case (state_d)
      HDR: begin
        out_valid_d = 1'b1;
        out_data_d  = {map_bit(HDR_SEQ[hdr_idx]), {IQ_W{1'b0}}};
      end
      PAY: begin
        if (full_d) begin
          out_valid_d = 1'b1;
          out_data_d  = mode_d ? {map_bit(shreg_d[7]), map_bit(shreg_d[6])}
                               : {map_bit(shreg_d[7]), {IQ_W{1'b0}}};
          out_last_d  = last_d && (sym_d == sym_max_d) && (rep_d == REP_W'(SPS - 1));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      sym_q       <= '0;
      rep_q       <= '0;
      shreg_q     <= '0;
      full_q      <= 1'b0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      sym_q       <= sym_d;
      rep_q       <= rep_d;
      shreg_q     <= shreg_d;
      full_q      <= full_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_tx_mod_framer.sv
// Directed bench for tx_mod_framer: one instance at SPS=1 (most scenarios) and one at SPS=4.
module tb_tx_mod_framer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_mode, a_in_valid, a_in_last, a_in_ready, a_out_valid, a_out_last, a_out_ready;
  logic [7:0]  a_in_data;
  logic [23:0] a_out_data;
  logic        b_mode, b_in_valid, b_in_last, b_in_ready, b_out_valid, b_out_last, b_out_ready;
  logic [7:0]  b_in_data;
  logic [23:0] b_out_data;

  tx_mod_framer #(.SPS(1)) dut_a (
    .clk(clk), .rst(rst), .mode(a_mode), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_last(a_in_last), .in_ready(a_in_ready), .out_valid(a_out_valid),
    .out_data(a_out_data), .out_last(a_out_last), .out_ready(a_out_ready)
  );

  tx_mod_framer #(.SPS(4)) dut_b (
    .clk(clk), .rst(rst), .mode(b_mode), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_last(b_in_last), .in_ready(b_in_ready), .out_valid(b_out_valid),
    .out_data(b_out_data), .out_last(b_out_last), .out_ready(b_out_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Randomised or forced out_ready for instance A.
  logic rnd_en = 1'b0;
  always @(posedge clk) begin
    #1;
    a_out_ready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic [24:0] capa[$];
  logic [24:0] capb[$];
  logic [24:0] expa[$];
  int lastcnt_a = 0;
  int lastcnt_b = 0;
  int frame_lows = 0;
  int last_gap = -1;
  logic        in_frame = 1'b0, after_last = 1'b0, prev_stall = 1'b0, prev_last;
  logic [23:0] prev_data;
  int lows = 0, gap = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_frame   = 1'b0;
      after_last = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {a_out_valid, a_out_last, a_out_data}, {1'b1, prev_last, prev_data});
      prev_stall = a_out_valid && !a_out_ready;
      prev_last  = a_out_last;
      prev_data  = a_out_data;
      if (after_last) begin
        if (!a_out_valid) gap++;
        else begin
          after_last = 1'b0;
          last_gap   = gap;
        end
      end
      if (!in_frame && a_out_valid) begin
        in_frame = 1'b1;
        lows     = 0;
      end else if (in_frame && !a_out_valid) begin
        lows++;
      end
      if (a_out_valid && a_out_ready) begin
        capa.push_back({a_out_last, a_out_data});
        if (a_out_last) begin
          in_frame   = 1'b0;
          frame_lows = lows;
          after_last = 1'b1;
          gap        = 0;
          lastcnt_a++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready) begin
      capb.push_back({b_out_last, b_out_data});
      if (b_out_last) lastcnt_b++;
    end
  end

  function automatic logic [11:0] amp(input logic b);
    return b ? 12'hA58 : 12'h5A8;
  endfunction

  task automatic exp_hdr();
    logic [15:0] h;
    h = 16'hEB90;
    for (int k = 0; k < 16; k++) expa.push_back({1'b0, amp(h[15-k]), 12'h000});
  endtask

  task automatic exp_byte(input logic [7:0] d, input logic m, input logic l);
    if (m) begin
      for (int j = 0; j < 4; j++)
        expa.push_back({l && (j == 3), amp(d[7-2*j]), amp(d[6-2*j])});
    end else begin
      for (int j = 0; j < 8; j++)
        expa.push_back({l && (j == 7), amp(d[7-j]), 12'h000});
    end
  endtask

  task automatic cmp_a(input string tag);
    int n;
    check({tag, "_len"}, capa.size(), expa.size());
    n = (capa.size() < expa.size()) ? capa.size() : expa.size();
    for (int i = 0; i < n; i++) check(tag, capa[i], expa[i]);
    capa.delete();
    expa.delete();
  endtask

  task automatic send_a(input logic [7:0] d, input logic l);
    int unsigned n;
    logic done;
    n = 0;
    done = 1'b0;
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_in_last  = l;
    while (!done) begin
      @(negedge clk);
      if (a_in_ready) done = 1'b1;
      else if (++n > 1000) begin
        check("send_a_timeout", 0, 1);
        done = 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_b(input logic [7:0] d, input logic l);
    int unsigned n;
    logic done;
    n = 0;
    done = 1'b0;
    b_in_valid = 1'b1;
    b_in_data  = d;
    b_in_last  = l;
    while (!done) begin
      @(negedge clk);
      if (b_in_ready) done = 1'b1;
      else if (++n > 1000) begin
        check("send_b_timeout", 0, 1);
        done = 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_a(input int target);
    int unsigned n;
    n = 0;
    while (lastcnt_a < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (lastcnt_a < target) check("wait_a_timeout", lastcnt_a, target);
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    logic [15:0] h;
    logic [24:0] e;
    int j;
    h = 16'hEB90;
    rst = 1'b1;
    a_mode = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_in_last = 1'b0;
    b_mode = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_last", a_out_last, 0);
    check("rst_in_ready", a_in_ready, 0);
    check("rst_out_data", a_out_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // QPSK single byte, plus first-header-sample latency
    base = lastcnt_a;
    a_mode = 1'b1; a_in_valid = 1'b1; a_in_data = 8'h1B; a_in_last = 1'b1;
    @(negedge clk);
    check("idle_in_ready", a_in_ready, 0);
    @(posedge clk); #1;
    check("hdr_latency", {a_out_valid, a_out_data}, {1'b1, 24'hA58000});
    send_a(8'h1B, 1'b1);
    a_in_valid = 1'b0;
    wait_a(base + 1);
    check("q_hdr3_i", capa[3][23:12], 12'h5A8);
    check("q_s0", capa[16], {1'b0, 12'h5A8, 12'h5A8});
    check("q_s1", capa[17], {1'b0, 12'h5A8, 12'hA58});
    check("q_s2", capa[18], {1'b0, 12'hA58, 12'h5A8});
    check("q_s3", capa[19], {1'b1, 12'hA58, 12'hA58});
    exp_hdr(); exp_byte(8'h1B, 1'b1, 1'b1);
    cmp_a("qpsk1");

    // BPSK with SPS=4 on instance B
    send_b(8'h80, 1'b0);
    send_b(8'h01, 1'b1);
    b_in_valid = 1'b0;
    j = 0;
    while (lastcnt_b < 1 && j < 3000) begin @(negedge clk); j++; end
    check("b_len", capb.size(), 128);
    for (int i = 0; i < 128 && i < capb.size(); i++) begin
      if (i < 64) e = {1'b0, amp(h[15 - i/4]), 12'h000};
      else e = {(i == 127), ((i < 68) || (i >= 124)) ? 12'hA58 : 12'h5A8, 12'h000};
      check("bpsk_sps4", capb[i], e);
    end
    capb.delete();

    // Backpressure, bytes back-to-back
    base = lastcnt_a;
    rnd_en = 1'b1;
    a_mode = 1'b0;
    send_a(8'hC3, 1'b0);
    send_a(8'h5A, 1'b0);
    send_a(8'h0F, 1'b1);
    a_in_valid = 1'b0;
    wait_a(base + 1);
    rnd_en = 1'b0;
    check("bp_lows", frame_lows, 1);
    exp_hdr(); exp_byte(8'hC3, 1'b0, 1'b0); exp_byte(8'h5A, 1'b0, 1'b0); exp_byte(8'h0F, 1'b0, 1'b1);
    cmp_a("backpressure");
    repeat (2) @(posedge clk); #1;

    // Underrun and mid-frame mode change
    base = lastcnt_a;
    a_mode = 1'b1;
    send_a(8'hA5, 1'b0);
    a_in_valid = 1'b0;
    a_mode = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("underrun_valid", a_out_valid, 0);
    @(posedge clk); #1;
    send_a(8'h3C, 1'b1);
    a_in_valid = 1'b0;
    wait_a(base + 1);
    exp_hdr(); exp_byte(8'hA5, 1'b1, 1'b0); exp_byte(8'h3C, 1'b1, 1'b1);
    cmp_a("underrun");
    repeat (2) @(posedge clk); #1;

    // Reset during payload
    base = lastcnt_a;
    a_mode = 1'b0;
    send_a(8'hFF, 1'b0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", a_out_valid, 0);
    check("midrst_ready", a_in_ready, 0);
    check("midrst_last", a_out_last, 0);
    a_in_valid = 1'b0;
    rst = 1'b0;
    capa.delete();
    check("midrst_nolast", lastcnt_a, base);
    @(posedge clk); #1;
    a_mode = 1'b1;
    send_a(8'h00, 1'b1);
    a_in_valid = 1'b0;
    wait_a(base + 1);
    exp_hdr(); exp_byte(8'h00, 1'b1, 1'b1);
    cmp_a("after_rst");
    repeat (2) @(posedge clk); #1;

    // Back-to-back frames, second frame in QPSK
    base = lastcnt_a;
    a_mode = 1'b0;
    send_a(8'h96, 1'b1);
    a_mode = 1'b1;
    send_a(8'h69, 1'b1);
    a_in_valid = 1'b0;
    wait_a(base + 2);
    check("b2b_idle_gap", last_gap, 1);
    exp_hdr(); exp_byte(8'h96, 1'b0, 1'b1);
    exp_hdr(); exp_byte(8'h69, 1'b1, 1'b1);
    cmp_a("b2b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
